// File: rtl/time_set_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// time_set_ctrl_pkg
//   Shared types and helpers for the watch time-set sequencer.
//   - tsc_state_t : mode FSM states (RUN, SET, COMMIT)
//   - FLD_*       : digit field indices, 0 = hour_h .. 5 = sec_l
//   - field_onehot: field index -> one-hot digit vector, bit5 = hour_h .. bit0 = sec_l
// ---------------------------------------------------------------------------
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET    = 2'd1,
        COMMIT = 2'd2
    } tsc_state_t;

    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] FLD_HOUR_H = 3'd0;
    localparam logic [2:0] FLD_HOUR_L = 3'd1;
    localparam logic [2:0] FLD_MIN_H  = 3'd2;
    localparam logic [2:0] FLD_MIN_L  = 3'd3;
    localparam logic [2:0] FLD_SEC_H  = 3'd4;
    localparam logic [2:0] FLD_SEC_L  = 3'd5;

    // Field 0 (hour_h) maps to the MSB so the vector reads left-to-right like the display.
    function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [2:0] fld);
        field_onehot = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (fld == 3'(i)) begin
                field_onehot[NUM_FIELDS-1-i] = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/time_set_ctrl_key_repeat_timer.sv
// ---------------------------------------------------------------------------
// key_repeat_timer
//   Auto-repeat generator for a held key. After `held` has been high for DELAY
//   consecutive cycles, rpt_pulse is high for one cycle; afterwards it fires
//   every PERIOD cycles while `held` stays high. Dropping `held` or raising
//   `restart` returns to the initial DELAY wait. rpt_pulse is combinational
//   and is never high in a cycle where restart is high.
//   Only built when TIME_SET_AUTOREPEAT_EN is defined.
// Ports
//   clk       in  clock
//   resetn    in  synchronous active-low reset
//   held      in  key held level
//   restart   in  restart the delay wait (other key activity / not editing)
//   rpt_pulse out one-cycle repeat request
// ---------------------------------------------------------------------------
`ifdef TIME_SET_AUTOREPEAT_EN
module key_repeat_timer #(
    parameter int DELAY  = 50_000_000,
    parameter int PERIOD = 20_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic held,
    input  logic restart,
    output logic rpt_pulse
);

    localparam int MAXC = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          first;   // still waiting out the initial DELAY

    assign rpt_pulse = held && !restart &&
                       (first ? (cnt == DELAY_LAST) : (cnt == PERIOD_LAST));

    always_ff @(posedge clk) begin
        if (!resetn || !held || restart) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (rpt_pulse) begin
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//   Mode sequencer for the six watch digit counters. Turns debounced key
//   events into RUN/SET/COMMIT mode, field selection, one-cycle increment
//   pulses, a run gate for the 1 s carry chain and a blink mask.
//   Optional feature macro: TIME_SET_AUTOREPEAT_EN (held-key auto-repeat).
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   tick_1s       1 s prescaler pulse
//   key_mode      press: enter/leave SET
//   key_next      press: next field (SET only)
//   key_inc       press: increment selected field (SET only)
//   key_inc_held  inc key held level (auto-repeat build only)
//   run_en        1 = counters advance (state RUN)
//   set_active    1 while in SET
//   field_sel     selected field, 0 = hour_h .. 5 = sec_l
//   inc_pulse     one-hot increment, bit5 = hour_h .. bit0 = sec_l
//   blink_mask    1 = blank digit, same order as inc_pulse
//   prescale_clr  high during COMMIT to restart the 1 s prescaler
//   state_dbg     current FSM state (tsc_state_t encoding)
// All outputs are registered, computed from next-state values.
// ---------------------------------------------------------------------------
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int BLINK_DIV     = 50_000_000,
    parameter int TIMEOUT_S     = 10,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  tick_1s,
    input  logic                  key_mode,
    input  logic                  key_next,
    input  logic                  key_inc,
    input  logic                  key_inc_held,
    output logic                  run_en,
    output logic                  set_active,
    output logic [2:0]            field_sel,
    output logic [NUM_FIELDS-1:0] inc_pulse,
    output logic [NUM_FIELDS-1:0] blink_mask,
    output logic                  prescale_clr,
    output logic [1:0]            state_dbg
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_S - 1);

    tsc_state_t            state, nxt_state;
    logic [2:0]            nxt_field;
    logic [NUM_FIELDS-1:0] nxt_inc, nxt_mask;
    logic [TW-1:0]         tmo_cnt, nxt_tmo;
    logic [BW-1:0]         blink_cnt, nxt_bcnt;
    logic                  blink_ph, nxt_ph;
    logic                  key_any;
    logic                  rpt_fire;

    assign key_any   = key_mode | key_next | key_inc;
    assign state_dbg = state;

`ifdef TIME_SET_AUTOREPEAT_EN
    // Any key press or leaving SET restarts the repeat wait, so a repeat can
    // never land in the same cycle as a real key_inc.
    key_repeat_timer #(
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD)
    ) u_key_repeat_timer (
        .clk       (clk),
        .resetn    (resetn),
        .held      (key_inc_held),
        .restart   (key_any || (state != SET)),
        .rpt_pulse (rpt_fire)
    );
`else
    logic unused_repeat;
    assign rpt_fire      = 1'b0;
    assign unused_repeat = key_inc_held ^ (REPEAT_DELAY > REPEAT_PERIOD);
`endif

    always_comb begin
        nxt_state = state;
        nxt_field = field_sel;
        nxt_inc   = '0;
        nxt_tmo   = tmo_cnt;
        nxt_bcnt  = blink_cnt + 1'b1;
        nxt_ph    = blink_ph;

        if (blink_cnt == BLINK_LAST) begin
            nxt_bcnt = '0;
            nxt_ph   = ~blink_ph;
        end
        // Restart the blink on any key so the edited digit is visible at once.
        if (key_any) begin
            nxt_bcnt = '0;
            nxt_ph   = 1'b0;
        end

        if (key_any || rpt_fire) begin
            nxt_tmo = '0;
        end else if (tick_1s && (state == SET)) begin
            nxt_tmo = tmo_cnt + 1'b1;
        end

        case (state)
            RUN: begin
                if (key_mode) begin
                    nxt_state = SET;
                    nxt_field = FLD_HOUR_H;
                    nxt_tmo   = '0;
                    nxt_bcnt  = '0;
                    nxt_ph    = 1'b0;
                end
            end
            SET: begin
                // Priority chain: mode > next > inc; lower keys are dropped.
                if (key_mode) begin
                    nxt_state = COMMIT;
                end else if (key_next) begin
                    nxt_field = (field_sel == FLD_SEC_L) ? FLD_HOUR_H : field_sel + 3'd1;
                end else if (key_inc || rpt_fire) begin
                    nxt_inc = field_onehot(field_sel);
                end else if (tick_1s && (tmo_cnt == TMO_LAST)) begin
                    nxt_state = COMMIT;
                end
            end
            COMMIT: begin
                nxt_state = RUN;
            end
            default: begin
                nxt_state = RUN;
            end
        endcase

        nxt_mask = ((nxt_state == SET) && nxt_ph) ? field_onehot(nxt_field) : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= RUN;
            field_sel    <= FLD_HOUR_H;
            inc_pulse    <= '0;
            blink_mask   <= '0;
            tmo_cnt      <= '0;
            blink_cnt    <= '0;
            blink_ph     <= 1'b0;
            run_en       <= 1'b1;
            set_active   <= 1'b0;
            prescale_clr <= 1'b0;
        end else begin
            state        <= nxt_state;
            field_sel    <= nxt_field;
            inc_pulse    <= nxt_inc;
            blink_mask   <= nxt_mask;
            tmo_cnt      <= nxt_tmo;
            blink_cnt    <= nxt_bcnt;
            blink_ph     <= nxt_ph;
            run_en       <= (nxt_state == RUN);
            set_active   <= (nxt_state == SET);
            prescale_clr <= (nxt_state == COMMIT);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with small timing parameters.
//   Expected increment pulses (value and cycle) are queued when the key is
//   driven; a negedge monitor pops and compares every non-zero inc_pulse.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;
    import time_set_ctrl_pkg::*;

    localparam int BLINK_DIV     = 4;
    localparam int TIMEOUT_S     = 3;
    localparam int REPEAT_DELAY  = 8;
    localparam int REPEAT_PERIOD = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick_1s = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_next = 1'b0;
    logic       key_inc = 1'b0;
    logic       key_inc_held = 1'b0;
    logic       run_en;
    logic       set_active;
    logic [2:0] field_sel;
    logic [5:0] inc_pulse;
    logic [5:0] blink_mask;
    logic       prescale_clr;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [5:0] exp_q[$];
    int         exp_t_q[$];

    time_set_ctrl #(
        .BLINK_DIV     (BLINK_DIV),
        .TIMEOUT_S     (TIMEOUT_S),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .tick_1s      (tick_1s),
        .key_mode     (key_mode),
        .key_next     (key_next),
        .key_inc      (key_inc),
        .key_inc_held (key_inc_held),
        .run_en       (run_en),
        .set_active   (set_active),
        .field_sel    (field_sel),
        .inc_pulse    (inc_pulse),
        .blink_mask   (blink_mask),
        .prescale_clr (prescale_clr),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one cycle of inputs, return 1 ns after the edge that sampled them.
    task automatic drive(input logic m, input logic n, input logic i, input logic t);
        key_mode = m;
        key_next = n;
        key_inc  = i;
        tick_1s  = t;
        @(posedge clk);
        #1;
        key_mode = 1'b0;
        key_next = 1'b0;
        key_inc  = 1'b0;
        tick_1s  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_inc(input logic [5:0] v, input int at_cyc);
        exp_q.push_back(v);
        exp_t_q.push_back(at_cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_run_en"},     32'(run_en),       32'd1);
        chk({tag, "_set_active"}, 32'(set_active),   32'd0);
        chk({tag, "_field_sel"},  32'(field_sel),    32'd0);
        chk({tag, "_inc_pulse"},  32'(inc_pulse),    32'd0);
        chk({tag, "_blink_mask"}, 32'(blink_mask),   32'd0);
        chk({tag, "_prescale"},   32'(prescale_clr), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (inc_pulse !== 6'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                assert (inc_pulse === 6'b0) else begin
                    failures++;
                    $error("FAIL inc_unexpected observed=%b expected=000000 cyc=%0d", inc_pulse, cyc);
                end
            end else begin
                logic [5:0] ev;
                int         et;
                ev = exp_q.pop_front();
                et = exp_t_q.pop_front();
                assert ((inc_pulse === ev) && (cyc == et)) else begin
                    failures++;
                    $error("FAIL inc_pulse observed=%b@%0d expected=%b@%0d", inc_pulse, cyc, ev, et);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset
        idle(3);
        chk_reset_outputs("reset");
        chk("reset_state", 32'(state_dbg), 32'(RUN));
        resetn = 1'b1;

        // 1: enter SET
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_set_active", 32'(set_active), 32'd1);
        chk("t1_run_en",     32'(run_en),     32'd0);
        chk("t1_field_sel",  32'(field_sel),  32'd0);
        chk("t1_blink_mask", 32'(blink_mask), 32'd0);
        chk("t1_state",      32'(state_dbg),  32'(SET));

        // 2: field walk with wrap, then increments
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            chk("t2_field_walk", 32'(field_sel), 32'(i % 6));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_field_2", 32'(field_sel), 32'd2);
        expect_inc(6'b001000, cyc + 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_inc_f2", 32'(inc_pulse), 32'b001000);
        idle(1);
        chk("t2_inc_f2_gone", 32'(inc_pulse), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_inc(6'b000100, cyc + 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_inc_f3", 32'(inc_pulse), 32'b000100);
        idle(1);
        chk("t2_inc_f3_gone", 32'(inc_pulse), 32'd0);

        // 3: blink on field 0 (3 -> 4 -> 5 -> 0)
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_field_0", 32'(field_sel), 32'd0);
        chk("t3_mask_after_key", 32'(blink_mask), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            chk("t3_blink", 32'(blink_mask), (((i / 4) % 2) == 1) ? 32'b100000 : 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_mask_cleared", 32'(blink_mask), 32'd0);
        chk("t3_field_1",      32'(field_sel),  32'd1);

        // 4: timeout with a restart at count 2
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_still_set_a", 32'(set_active), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_still_set_b", 32'(set_active), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_commit_state",    32'(state_dbg),    32'(COMMIT));
        chk("t4_commit_prescale", 32'(prescale_clr), 32'd1);
        chk("t4_commit_run_en",   32'(run_en),       32'd0);
        chk("t4_commit_set",      32'(set_active),   32'd0);
        idle(1);
        chk("t4_run_en",     32'(run_en),       32'd1);
        chk("t4_prescale_0", 32'(prescale_clr), 32'd0);
        chk("t4_field_kept", 32'(field_sel),    32'd2);
        // keys ignored in RUN
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_run_next_ignored", 32'(field_sel), 32'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("t4_run_mask", 32'(blink_mask), 32'd0);

        // 5: simultaneous keys in SET
        idle($urandom_range(1, 4));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_entry_field", 32'(field_sel), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_field_1", 32'(field_sel), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_left_set",  32'(set_active),   32'd0);
        chk("t5_prescale",  32'(prescale_clr), 32'd1);
        chk("t5_field_kept", 32'(field_sel),   32'd1);
        chk("t5_no_inc",    32'(inc_pulse),    32'd0);
        idle(1);
        chk("t5_run_en", 32'(run_en), 32'd1);

`ifdef TIME_SET_AUTOREPEAT_EN
        // 6: auto-repeat, then reset mid-hold
        begin
            int c0;
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            chk("t6_set", 32'(set_active), 32'd1);
            c0 = cyc;
            key_inc_held = 1'b1;
            expect_inc(6'b100000, c0 + REPEAT_DELAY);
            expect_inc(6'b100000, c0 + REPEAT_DELAY + REPEAT_PERIOD);
            expect_inc(6'b100000, c0 + REPEAT_DELAY + 2 * REPEAT_PERIOD);
            expect_inc(6'b100000, c0 + REPEAT_DELAY + 3 * REPEAT_PERIOD);
            idle(19);
            key_inc_held = 1'b0;
            idle(4);
            chk("t6_repeat_drained", 32'(exp_q.size()), 32'd0);
            chk("t6_still_set", 32'(set_active), 32'd1);

            c0 = cyc;
            key_inc_held = 1'b1;
            expect_inc(6'b100000, c0 + REPEAT_DELAY);
            idle(9);
            resetn = 1'b0;
            idle(1);
            chk_reset_outputs("t6_reset");
            idle(1);
            resetn = 1'b1;
            idle(12);
            key_inc_held = 1'b0;
            chk("t6_after_reset_run", 32'(run_en), 32'd1);
        end
`endif

        idle(3);
        chk("inc_missing", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
